reset_sequencer: RTL and testbench

Central reset controller for the clock domain's reset tree. It collects reset requests from several requesters, such as a software register or a watchdog. It asserts `NUM_DOMAINS` downstream reset lines together, holds them for a fixed stretch, then releases them one at a time in ascending index order with a fixed gap between releases. When the sequence finishes it acknowledges every requester whose request it served, and it runs the same sequence automatically after power-on.

---
 rtl/reset_sequencer.sv | 108 ++++++++++
 tb/tb_reset_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer: asserts all domain resets on power-on or request, holds, then releases them in index order.
// Define RESET_SEQ_REQ_SYNC_EN to pass req_i through a two-flop synchronizer.
module reset_sequencer #(
    parameter int NUM_DOMAINS = 4,
    parameter int NUM_REQ     = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_ni,
    input  logic [NUM_REQ-1:0]     req_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic [NUM_DOMAINS-1:0] domain_rst_o,
    output logic                   busy_o,
    output logic [NUM_REQ:0]       cause_o
);
    localparam int IDX_W = NUM_DOMAINS > 1 ? $clog2(NUM_DOMAINS) : 1;

    typedef enum logic [1:0] {RUN, ASSERT, RELEASE, DONE} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic [IDX_W-1:0]       idx;
    logic [NUM_REQ-1:0]     mask;
    logic [NUM_REQ-1:0]     req;
    logic [NUM_DOMAINS-1:0] held;
    logic                   last;

`ifdef RESET_SEQ_REQ_SYNC_EN
    logic [NUM_REQ-1:0] req_meta;
    always_ff @(posedge clk or negedge rst_ni)
        if (!rst_ni) {req, req_meta} <= '0;
        else         {req, req_meta} <= {req_meta, req_i};
`else
    assign req = req_i;
`endif

    // domains above the current release index are still held in reset
    for (genvar k = 0; k < NUM_DOMAINS; k++) begin : g_held
        assign held[k] = idx < IDX_W'(k);
    end

    assign last = idx == IDX_W'(NUM_DOMAINS - 1);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= ASSERT;
            cnt          <= '0;
            idx          <= '0;
            mask         <= '0;
            domain_rst_o <= '1;
            busy_o       <= 1'b1;
            ack_o        <= '0;
            cause_o      <= (NUM_REQ + 1)'(1);
        end else begin
            ack_o <= '0;
            case (state)
                RUN: begin
                    domain_rst_o <= '0;
                    busy_o       <= 1'b0;
                    if (|req) begin
                        mask    <= req;
                        cause_o <= {req, 1'b0};
                        cnt     <= '0;
                        state   <= ASSERT;
                    end
                end
                ASSERT: begin
                    domain_rst_o <= '1;
                    busy_o       <= 1'b1;
                    mask         <= mask | req;
                    cause_o      <= cause_o | {req, 1'b0};
                    cnt          <= cnt + 1'b1;
                    if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                        cnt   <= '0;
                        idx   <= '0;
                        state <= RELEASE;
                    end
                end
                RELEASE: begin
                    domain_rst_o <= held;
                    busy_o       <= 1'b1;
                    cnt          <= cnt + 1'b1;
                    // only requesters not already captured restart, so held levels do not loop forever
                    if (|(req & ~mask)) begin
                        mask    <= mask | req;
                        cause_o <= cause_o | {req, 1'b0};
                        cnt     <= '0;
                        state   <= ASSERT;
                    end else if (last) begin
                        state <= DONE;
                    end else if (cnt == CNT_W'(STAGE_GAP - 1)) begin
                        cnt <= '0;
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    domain_rst_o <= '0;
                    busy_o       <= 1'b1;
                    ack_o        <= mask;
                    mask         <= '0;
                    state        <= RUN;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scoreboard bench for reset_sequencer with default parameters.
module tb_reset_sequencer;
    logic       clk = 1'b0;
    logic       rst_ni = 1'b1;
    logic [1:0] req_i = '0;
    logic [1:0] ack_o;
    logic [3:0] domain_rst_o;
    logic       busy_o;
    logic [2:0] cause_o;

    reset_sequencer dut (
        .clk(clk), .rst_ni(rst_ni), .req_i(req_i), .ack_o(ack_o),
        .domain_rst_o(domain_rst_o), .busy_o(busy_o), .cause_o(cause_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] dom;
        logic [1:0] ack;
        logic       busy;
        logic [2:0] cause;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   t0, r;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic push(input int c, input logic [3:0] d, input logic [1:0] a,
                        input logic b, input logic [2:0] ca);
        exp_t e;
        e.cyc = c; e.dom = d; e.ack = a; e.busy = b; e.cause = ca;
        q.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            chk("domain_rst", 32'(domain_rst_o), 32'(e.dom));
            chk("ack", 32'(ack_o), 32'(e.ack));
            chk("busy", 32'(busy_o), 32'(e.busy));
            chk("cause", 32'(cause_o), 32'(e.cause));
        end
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic check_reset_values();
        chk("rst_domain", 32'(domain_rst_o), 32'hf);
        chk("rst_ack", 32'(ack_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h1);
        chk("rst_cause", 32'(cause_o), 32'h1);
    endtask

    task automatic push_power_on(input int rr);
        push(rr + 15, 4'b1111, 2'b00, 1'b1, 3'b001);
        push(rr + 16, 4'b1110, 2'b00, 1'b1, 3'b001);
        push(rr + 20, 4'b1100, 2'b00, 1'b1, 3'b001);
        push(rr + 24, 4'b1000, 2'b00, 1'b1, 3'b001);
        push(rr + 28, 4'b0000, 2'b00, 1'b1, 3'b001);
        push(rr + 29, 4'b0000, 2'b00, 1'b1, 3'b001);
        push(rr + 30, 4'b0000, 2'b00, 1'b0, 3'b001);
    endtask

    initial begin
        // power-on
        #2 rst_ni = 1'b0;
        #1 check_reset_values();
        step();
        step();
        rst_ni = 1'b1;
        r = cyc + 1;
        push_power_on(r);
        run_to(r + 30);

        // single request, held until acknowledged
        t0 = cyc + 1;
        req_i = 2'b10;
        push(t0,      4'b0000, 2'b00, 1'b0, 3'b100);
        push(t0 + 1,  4'b1111, 2'b00, 1'b1, 3'b100);
        push(t0 + 16, 4'b1111, 2'b00, 1'b1, 3'b100);
        push(t0 + 17, 4'b1110, 2'b00, 1'b1, 3'b100);
        push(t0 + 21, 4'b1100, 2'b00, 1'b1, 3'b100);
        push(t0 + 25, 4'b1000, 2'b00, 1'b1, 3'b100);
        push(t0 + 29, 4'b0000, 2'b00, 1'b1, 3'b100);
        push(t0 + 30, 4'b0000, 2'b10, 1'b1, 3'b100);
        push(t0 + 31, 4'b0000, 2'b00, 1'b0, 3'b100);
        run_to(t0 + 30);
        req_i = 2'b00;
        run_to(t0 + 33);

        // merge during hold
        t0 = cyc + 1;
        req_i = 2'b01;
        push(t0 + 1,  4'b1111, 2'b00, 1'b1, 3'b010);
        push(t0 + 4,  4'b1111, 2'b00, 1'b1, 3'b010);
        push(t0 + 5,  4'b1111, 2'b00, 1'b1, 3'b110);
        push(t0 + 16, 4'b1111, 2'b00, 1'b1, 3'b110);
        push(t0 + 17, 4'b1110, 2'b00, 1'b1, 3'b110);
        push(t0 + 29, 4'b0000, 2'b00, 1'b1, 3'b110);
        push(t0 + 30, 4'b0000, 2'b11, 1'b1, 3'b110);
        push(t0 + 31, 4'b0000, 2'b00, 1'b0, 3'b110);
        run_to(t0 + 4);
        req_i = 2'b11;
        run_to(t0 + 30);
        req_i = 2'b00;
        run_to(t0 + 33);

        // restart during release
        t0 = cyc + 1;
        req_i = 2'b01;
        push(t0 + 17, 4'b1110, 2'b00, 1'b1, 3'b010);
        push(t0 + 21, 4'b1100, 2'b00, 1'b1, 3'b010);
        push(t0 + 22, 4'b1100, 2'b00, 1'b1, 3'b110);
        push(t0 + 23, 4'b1111, 2'b00, 1'b1, 3'b110);
        push(t0 + 38, 4'b1111, 2'b00, 1'b1, 3'b110);
        push(t0 + 39, 4'b1110, 2'b00, 1'b1, 3'b110);
        push(t0 + 51, 4'b0000, 2'b00, 1'b1, 3'b110);
        push(t0 + 52, 4'b0000, 2'b11, 1'b1, 3'b110);
        push(t0 + 53, 4'b0000, 2'b00, 1'b0, 3'b110);
        run_to(t0 + 21);
        req_i = 2'b11;
        run_to(t0 + 22);
        req_i = 2'b01;
        run_to(t0 + 52);
        req_i = 2'b00;
        run_to(t0 + 55);

        // reset mid-sequence, request lost
        t0 = cyc + 1;
        req_i = 2'b10;
        push(t0 + 1,  4'b1111, 2'b00, 1'b1, 3'b100);
        push(t0 + 17, 4'b1110, 2'b00, 1'b1, 3'b100);
        run_to(t0 + 20);
        #2 rst_ni = 1'b0;
        req_i = 2'b00;
        #1 check_reset_values();
        step();
        rst_ni = 1'b1;
        r = cyc + 1;
        push_power_on(r);
        run_to(r + 32);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
